test_monitor: RTL
=================

# test_monitor

Synthesizable self-check monitor for riscv-tests style programs, instantiated beside the core in `riscv_soc`. It snoops the register-file write port and the jump interface, then produces a sticky pass/fail/timeout verdict. It also captures the failing test number and keeps a bounded ring of recent jumps. This lets the same check run on FPGA and under a lightweight bench without hierarchical peeking.

## Interface
- `DATA_WIDTH`, 32: register/address width.
- `DONE_REG`, 26: register index whose write of value 1 signals test end.
- `PASS_REG`, 27: register index holding the pass flag (1 = pass).
- `TNUM_REG`, 3: register index holding the current test number.
- `SETTLE_CYCLES`, 5: cycles between the done write and the verdict; legal range is 1 or more.
- `TIMEOUT_CYCLES`, 500: cycle budget counted from reset release.
- `TRACE_DEPTH`, 8: jump-trace ring entries; must be a power of 2, 2 or more.
- `clk` in 1: clock.
- `rstn` in 1: asynchronous, active-low reset.
- `wb_en` in 1: register-file write enable.
- `wb_addr` in 5: register-file write index.
- `wb_data` in DATA_WIDTH: register-file write data.
- `jump` in 1: taken jump or branch this cycle.
- `inst_addr` in DATA_WIDTH: PC of the jumping instruction.
- `jump_addr` in DATA_WIDTH: jump target.
- `trace_rd_en` in 1: pop one trace entry.
- `status` out 2: 0 = RUN, 1 = PASS, 2 = FAIL, 3 = TIMEOUT.
- `done` out 1: a verdict has been reached; sticky.
- `test_num` out DATA_WIDTH: last value written to TNUM_REG.
- `cycle_count` out DATA_WIDTH: cycles since reset; freezes at the verdict.
- `trace_rd_valid` out 1: the trace data is valid this cycle.
- `trace_rd_src` out DATA_WIDTH: popped jump source.
- `trace_rd_dst` out DATA_WIDTH: popped jump target.
- `trace_count` out log2(TRACE_DEPTH)+1: number of occupied entries.
- `trace_ovf` out 1: sticky flag, set when an entry was overwritten.

## Operation
- **Reset values:** all outputs are 0 and the state is RUN.
- **Shadow registers:** pass_shadow and test_num are updated on any `wb_en` write to their index.
  - Writes with `wb_addr` == 0 are ignored.
- **States:** RUN, SETTLE, PASS, FAIL, TIMEOUT.
- **RUN → SETTLE:** on a sampled write of exactly 1 to DONE_REG. Other values do not trigger the transition. The settle counter is loaded with SETTLE_CYCLES.
- **SETTLE:** the counter decrements every cycle. A further DONE_REG write does not restart it. Writes to PASS_REG still update pass_shadow.
- **Leaving SETTLE:** when the counter reaches 0, go to PASS if pass_shadow == 1, otherwise FAIL.
- **Timeout:** in RUN or SETTLE, when cycle_count reaches TIMEOUT_CYCLES, go to TIMEOUT.
  - If the settle expiry and the timeout occur on the same edge, PASS/FAIL wins.
- **Terminal states:** PASS, FAIL and TIMEOUT hold until reset.
  - `cycle_count` and `test_num` freeze.
  - Trace capture stops, but popping continues.
- **Trace ring:**
  - Push {`inst_addr`, `jump_addr`} on `jump` while in RUN or SETTLE.
  - When full, the oldest entry is overwritten and `trace_ovf` is set.
  - Popping while empty is ignored.
  - Simultaneous push and pop while full pops the oldest entry, pushes the new one, leaves the count unchanged and does not set overflow.
- **Width rules:** `cycle_count` saturates at all-ones. Pointers wrap modulo TRACE_DEPTH.

## Timing
- Inputs are sampled on the rising edge of `clk`. All outputs are registered.
- A done write sampled at edge N gives `status` and `done` updated at edge N+SETTLE_CYCLES+1.
- The pass check uses pass_shadow as of edge N+SETTLE_CYCLES.
- Timeout: `status` becomes 3 on the edge where `cycle_count` would become TIMEOUT_CYCLES.
- Trace pop: `trace_rd_en` sampled at edge N gives `trace_rd_valid` high and the data valid after edge N+1, for one cycle.
- A push at edge N is visible in `trace_count` after edge N+1.
- Asserting `rstn` low mid-settle or mid-pop clears everything immediately (asynchronous reset).

## Configuration
- **`TEST_MONITOR_JUMP_TRACE_EN` defined:** the trace ring and its ports are fully functional.
- **Undefined:**
  - No trace storage is built.
  - `trace_rd_valid`, `trace_rd_src`, `trace_rd_dst`, `trace_count` and `trace_ovf` are tied to 0.
  - `trace_rd_en` is ignored.
  - The verdict logic is unchanged.

## Structure
- **Shared package `riscv_defines`:** status encodings (ST_RUN, ST_PASS, ST_FAIL, ST_TIMEOUT) and default register indices.
- **One sub-module `jump_trace_ring`:** the ring buffer (push/pop, overwrite, count, overflow), instantiated only under the macro.
- Everything else (FSM and counters) lives in `test_monitor`.

## Test plan
- **Pass:**
  - Stimulus: write x3=5, x27=1, then x26=1 at cycle 40.
  - Expected: status=1 and done=1 at cycle 46; test_num=5; cycle_count frozen at 46.
- **Fail with late pass write:**
  - Stimulus: write x27=0, then x26=1, then x27=1 two cycles later.
  - Expected: status=1, because the late write lands inside the settle window.
  - Variant: write x27=1 after the verdict; expected: status stays 2.
- **Timeout:**
  - Stimulus: TIMEOUT_CYCLES=100 and no done write.
  - Expected: status=3 at cycle_count=100. A later x26=1 has no effect.
- **Filtering:**
  - Stimulus: write x26=2, then write x0=1 with x26 still 2.
  - Expected: status stays 0.
- **Trace overflow:**
  - Stimulus: 10 jumps with TRACE_DEPTH=8, then 8 pops.
  - Expected: trace_ovf=1; the pops return jumps 3..10 in order; trace_count=0.
  - Stimulus: push and pop in the same cycle while full.
  - Expected: count stays 8 and no overflow.
- **Reset mid-settle:**
  - Stimulus: drop rstn 2 cycles after x26=1.
  - Expected: all outputs are 0 and the state is RUN after rstn rises.

Source files
------------

// File: rtl/riscv_defines.sv
// Shared encodings for the riscv-tests self-check monitor: verdict codes,
// monitor FSM states and the conventional register indices.
package riscv_defines;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } status_e;

  typedef enum logic [2:0] {
    S_RUN,
    S_SETTLE,
    S_PASS,
    S_FAIL,
    S_TIMEOUT
  } state_e;

  // riscv-tests convention: x26 = done flag, x27 = pass flag, x3 (gp) = test number
  localparam int DEF_DONE_REG = 26;
  localparam int DEF_PASS_REG = 27;
  localparam int DEF_TNUM_REG = 3;

endpackage

// File: rtl/jump_trace_ring.sv
// Overwriting ring of recent {source, target} jump pairs with a two-stage
// registered read port, occupancy count and sticky overflow flag.
module jump_trace_ring #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    push,
  input  logic [DATA_WIDTH-1:0]   push_src,
  input  logic [DATA_WIDTH-1:0]   push_dst,
  input  logic                    pop,
  output logic                    rd_valid,
  output logic [DATA_WIDTH-1:0]   rd_src,
  output logic [DATA_WIDTH-1:0]   rd_dst,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    ovf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [2*DATA_WIDTH-1:0] mem [DEPTH];
  logic [2*DATA_WIDTH-1:0] stage_reg;
  logic [PTR_W-1:0]        wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]        occ_reg, count_reg;
  logic                    pop_q_reg, valid_reg, ovf_reg;
  logic [DATA_WIDTH-1:0]   src_reg, dst_reg;
  logic                    full, pop_ok;

  assign full   = (occ_reg == CNT_W'(DEPTH));
  assign pop_ok = pop && (occ_reg != '0);

  // Read-before-write: a push into the slot being popped still yields the old entry.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= {push_src, push_dst};
    stage_reg <= mem[rd_ptr_reg];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
      count_reg  <= '0;
      pop_q_reg  <= 1'b0;
      valid_reg  <= 1'b0;
      ovf_reg    <= 1'b0;
      src_reg    <= '0;
      dst_reg    <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop_ok || (push && full)) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      if (push && !pop_ok) begin
        if (full) ovf_reg <= 1'b1;
        else      occ_reg <= occ_reg + CNT_W'(1);
      end else if (!push && pop_ok) begin
        occ_reg <= occ_reg - CNT_W'(1);
      end
      count_reg <= occ_reg;
      pop_q_reg <= pop_ok;
      valid_reg <= pop_q_reg;
      if (pop_q_reg) {src_reg, dst_reg} <= stage_reg;
    end
  end

  assign rd_valid = valid_reg;
  assign rd_src   = src_reg;
  assign rd_dst   = dst_reg;
  assign count    = count_reg;
  assign ovf      = ovf_reg;

endmodule

// File: rtl/test_monitor.sv
// Snoops register writes and jumps to produce a sticky pass/fail/timeout verdict.
// Define TEST_MONITOR_JUMP_TRACE_EN to build the jump-trace ring.
module test_monitor
  import riscv_defines::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int DONE_REG       = DEF_DONE_REG,
  parameter int PASS_REG       = DEF_PASS_REG,
  parameter int TNUM_REG       = DEF_TNUM_REG,
  parameter int SETTLE_CYCLES  = 5,
  parameter int TIMEOUT_CYCLES = 500,
  parameter int TRACE_DEPTH    = 8
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          wb_en,
  input  logic [4:0]                    wb_addr,
  input  logic [DATA_WIDTH-1:0]         wb_data,
  input  logic                          jump,
  input  logic [DATA_WIDTH-1:0]         inst_addr,
  input  logic [DATA_WIDTH-1:0]         jump_addr,
  input  logic                          trace_rd_en,
  output logic [1:0]                    status,
  output logic                          done,
  output logic [DATA_WIDTH-1:0]         test_num,
  output logic [DATA_WIDTH-1:0]         cycle_count,
  output logic                          trace_rd_valid,
  output logic [DATA_WIDTH-1:0]         trace_rd_src,
  output logic [DATA_WIDTH-1:0]         trace_rd_dst,
  output logic [$clog2(TRACE_DEPTH):0]  trace_count,
  output logic                          trace_ovf
);

  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);

  state_e                 state_reg;
  status_e                status_reg;
  logic                   done_reg;
  logic [SETTLE_W-1:0]    settle_cnt_reg;
  logic [DATA_WIDTH-1:0]  cycle_count_reg, cycle_count_next;
  logic [DATA_WIDTH-1:0]  test_num_reg, pass_shadow_reg;
  logic                   wr_valid, done_wr, pass_wr, tnum_wr, active, timeout_hit;

  assign wr_valid = wb_en && (wb_addr != 5'd0);
  assign done_wr  = wr_valid && (wb_addr == 5'(DONE_REG)) && (wb_data == DATA_WIDTH'(1));
  assign pass_wr  = wr_valid && (wb_addr == 5'(PASS_REG));
  assign tnum_wr  = wr_valid && (wb_addr == 5'(TNUM_REG));
  assign active   = (state_reg == S_RUN) || (state_reg == S_SETTLE);

  assign cycle_count_next = (cycle_count_reg == '1) ? cycle_count_reg
                                                    : cycle_count_reg + DATA_WIDTH'(1);
  assign timeout_hit = (cycle_count_next == DATA_WIDTH'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg       <= S_RUN;
      status_reg      <= ST_RUN;
      done_reg        <= 1'b0;
      settle_cnt_reg  <= '0;
      cycle_count_reg <= '0;
      test_num_reg    <= '0;
      pass_shadow_reg <= '0;
    end else begin
      if (pass_wr) pass_shadow_reg <= wb_data;
      if (active) begin
        cycle_count_reg <= cycle_count_next;
        if (tnum_wr) test_num_reg <= wb_data;
      end
      case (state_reg)
        S_RUN: begin
          if (timeout_hit) begin
            state_reg  <= S_TIMEOUT;
            status_reg <= ST_TIMEOUT;
            done_reg   <= 1'b1;
          end else if (done_wr) begin
            state_reg      <= S_SETTLE;
            settle_cnt_reg <= SETTLE_W'(SETTLE_CYCLES);
          end
        end
        S_SETTLE: begin
          // Settle expiry is checked first so it beats a coincident timeout.
          if (settle_cnt_reg == '0) begin
            done_reg <= 1'b1;
            if (pass_shadow_reg == DATA_WIDTH'(1)) begin
              state_reg  <= S_PASS;
              status_reg <= ST_PASS;
            end else begin
              state_reg  <= S_FAIL;
              status_reg <= ST_FAIL;
            end
          end else if (timeout_hit) begin
            state_reg  <= S_TIMEOUT;
            status_reg <= ST_TIMEOUT;
            done_reg   <= 1'b1;
          end else begin
            settle_cnt_reg <= settle_cnt_reg - SETTLE_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign status      = status_reg;
  assign done        = done_reg;
  assign test_num    = test_num_reg;
  assign cycle_count = cycle_count_reg;

`ifdef TEST_MONITOR_JUMP_TRACE_EN
  jump_trace_ring #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (TRACE_DEPTH)
  ) u_trace (
    .clk      (clk),
    .rstn     (rstn),
    .push     (jump && active),
    .push_src (inst_addr),
    .push_dst (jump_addr),
    .pop      (trace_rd_en),
    .rd_valid (trace_rd_valid),
    .rd_src   (trace_rd_src),
    .rd_dst   (trace_rd_dst),
    .count    (trace_count),
    .ovf      (trace_ovf)
  );
`else
  logic unused_trace;
  assign unused_trace   = ^{trace_rd_en, jump, inst_addr, jump_addr};
  assign trace_rd_valid = 1'b0;
  assign trace_rd_src   = '0;
  assign trace_rd_dst   = '0;
  assign trace_count    = '0;
  assign trace_ovf      = 1'b0;
`endif

endmodule
